quad_input_filter: RTL and testbench
====================================

QUAD_INPUT_FILTER -- requirements
Module: quad_input_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth per channel (legal 2..4).
REQ-002 Parameter FILT_CYCLES, default 8, SHALL set the consecutive stable cycles needed to accept a new level (legal 1..255).
REQ-003 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 A  input  1  SHALL be the raw, asynchronous encoder channel A.
REQ-006 B  input  1  SHALL be the raw, asynchronous encoder channel B.
REQ-007 enable  input  1  SHALL gate filtering; when low, outputs hold.
REQ-008 err_clear  input  1  SHALL zero err_count when high on a clock edge.
REQ-009 A_out  output  1  SHALL be the filtered channel A, driving the decoder's A.
REQ-010 B_out  output  1  SHALL be the filtered channel B, driving the decoder's B.
REQ-011 ready  output  1  SHALL be high once A_out/B_out are valid after reset.
REQ-012 step  output  1  SHALL be a one-cycle pulse when exactly one of A_out/B_out changed.
REQ-013 illegal  output  1  SHALL be a one-cycle pulse when A_out and B_out changed on the same edge.
REQ-014 err_count  output  8  SHALL be the saturating count of illegal events.

Function
REQ-015 Each channel SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the synchronized level s.
REQ-016 FSM states: INIT and RUN; reset SHALL enter INIT.
REQ-017 INIT SHALL count SYNC_STAGES edges, then load A_out/B_out directly from s, set ready, and enter RUN; no step/illegal pulse on that load.
REQ-018 In RUN with enable high, per channel: s equal to output -> counter cleared to 0; s differs and counter < FILT_CYCLES-1 -> counter increments; s differs and counter = FILT_CYCLES-1 -> output takes s, counter clears.
REQ-019 Latency: a pin level held stable SHALL reach its output on the (SYNC_STAGES+FILT_CYCLES)th rising edge, counting the first edge that samples it as edge 1.
REQ-020 A synchronized pulse shorter than FILT_CYCLES cycles SHALL be rejected, leaving the output and the next attempt's count from 0.
REQ-021 With enable low, counters SHALL be held at 0, outputs hold, step/illegal stay 0; synchronizers keep running.
REQ-022 step and illegal SHALL be registered, asserted the cycle after the output edge, never both high.
REQ-023 err_count SHALL increment on each illegal pulse and saturate at 255.
REQ-024 err_clear and an illegal event in the same cycle SHALL yield err_count = 1.
REQ-025 Channels SHALL filter independently; FILT_CYCLES = 1 SHALL accept a level after one differing synchronized sample.

Reset
REQ-026 On reset, synchronizer flops, counters, A_out, B_out, ready, step, illegal, and err_count SHALL all be 0.
REQ-027 Reset asserted mid-filtering SHALL discard partial counts and re-run INIT.

Verification
REQ-028 A=B=1 through reset release (defaults) -> ready=1 with A_out=B_out=1 after 2 edges, step=illegal=0.
REQ-029 After ready, A 0->1 held (defaults) -> A_out rises on edge 10, step pulses once on edge 11.
REQ-030 A glitch high for 5 cycles then low (FILT_CYCLES=8) -> A_out stays 0, no step.
REQ-031 A and B toggle together and are held -> A_out/B_out change on the same edge, illegal pulses once, err_count=1.
REQ-032 300 illegal events, then err_clear -> err_count holds 255, then reads 0.
REQ-033 enable low during an A change, then high -> A_out held while low; after enable rises, changes 8 edges later.

Source files
------------

// File: rtl/quad_input_filter_if.sv
// Signal bundle between a quadrature input filter and its user: the raw
// encoder pins and controls going in, the filtered levels and event pulses coming out.
interface quad_input_filter_if;
  logic       A;
  logic       B;
  logic       enable;
  logic       err_clear;
  logic       A_out;
  logic       B_out;
  logic       ready;
  logic       step;
  logic       illegal;
  logic [7:0] err_count;

  modport master (
    output A, B, enable, err_clear,
    input  A_out, B_out, ready, step, illegal, err_count
  );

  modport slave (
    input  A, B, enable, err_clear,
    output A_out, B_out, ready, step, illegal, err_count
  );
endinterface

// File: rtl/quad_input_filter.sv
// Synchronizes and debounces quadrature channels A/B, flags single-channel
// steps and simultaneous (illegal) transitions, and counts the illegal events.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 8
) (
  input logic            clk,
  input logic            reset,
  quad_input_filter_if.slave bus
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   load;
  logic [1:0]             init_cnt;
  logic [SYNC_STAGES-1:0] sync [2];
  logic [7:0]             cnt  [2];
  logic [1:0]             raw;
  logic [1:0]             s;
  logic [1:0]             s_next;
  logic [1:0]             out;
  logic [1:0]             prev;
  logic [1:0]             chg;
  logic                   run_en;
  logic                   step_d;
  logic                   illegal_d;
  logic                   ready;
  logic                   step;
  logic                   illegal;
  logic [7:0]             err_count;

  assign raw = {bus.B, bus.A};

  always_comb begin
    for (int unsigned ch = 0; ch < 2; ch++) begin
      s[ch]      = sync[ch][SYNC_STAGES-1];
      s_next[ch] = sync[ch][SYNC_STAGES-2];
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      INIT: begin
        if (init_cnt == 2'(SYNC_STAGES - 1)) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Edge events come from comparing the output with its one-cycle-delayed copy,
  // so step/illegal land the cycle after the output moves.
  assign chg       = out ^ prev;
  assign run_en    = (state == RUN) && bus.enable;
  assign step_d    = run_en && (chg[0] ^ chg[1]);
  assign illegal_d = run_en && (&chg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      out       <= '0;
      prev      <= '0;
      ready     <= 1'b0;
      step      <= 1'b0;
      illegal   <= 1'b0;
      err_count <= '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        sync[ch] <= '0;
        cnt[ch]  <= '0;
      end
    end else begin
      state    <= state_next;
      init_cnt <= (state == INIT) ? init_cnt + 2'd1 : '0;
      prev     <= out;
      step     <= step_d;
      illegal  <= illegal_d;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        sync[ch] <= {sync[ch][SYNC_STAGES-2:0], raw[ch]};
      end

      // The load takes the level shifting into the last sync stage this edge,
      // so outputs and s agree on the first RUN cycle.
      if (load) begin
        out   <= s_next;
        prev  <= s_next;
        ready <= 1'b1;
        for (int unsigned ch = 0; ch < 2; ch++) cnt[ch] <= '0;
      end else if (run_en) begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
          if (s[ch] == out[ch]) begin
            cnt[ch] <= '0;
          end else if (cnt[ch] == 8'(FILT_CYCLES - 1)) begin
            out[ch] <= s[ch];
            cnt[ch] <= '0;
          end else begin
            cnt[ch] <= cnt[ch] + 8'd1;
          end
        end
      end else begin
        for (int unsigned ch = 0; ch < 2; ch++) cnt[ch] <= '0;
      end

      if (bus.err_clear) begin
        err_count <= illegal_d ? 8'd1 : '0;
      end else if (illegal_d && (err_count != '1)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign bus.A_out     = out[0];
  assign bus.B_out     = out[1];
  assign bus.ready     = ready;
  assign bus.step      = step;
  assign bus.illegal   = illegal;
  assign bus.err_count = err_count;

endmodule

// File: tb/tb_quad_input_filter.sv
// Directed checks of the quadrature input filter: default build plus a
// three-stage synchronizer / single-cycle filter build.
module tb_quad_input_filter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  quad_input_filter_if bus ();
  quad_input_filter_if bus2 ();

  quad_input_filter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  quad_input_filter #(.SYNC_STAGES(3), .FILT_CYCLES(1)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic a, input logic b);
    bus.A = a;
    bus.B = b;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    bus.A = 1'b1;
    bus.B = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.ready, bus.A_out, bus.B_out, bus.step, bus.illegal} !== 5'b0 || bus.err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: got rdy/A/B/stp/ill=%b err=%0d want 00000 err=0",
               {bus.ready, bus.A_out, bus.B_out, bus.step, bus.illegal}, bus.err_count);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_edge1: got %b want 0", bus.ready);
    end
    tick();
    checks++;
    if ({bus.ready, bus.A_out, bus.B_out, bus.step, bus.illegal} !== 5'b11100) begin
      failures++;
      $display("FAIL init_load: got rdy/A/B/stp/ill=%b want 11100",
               {bus.ready, bus.A_out, bus.B_out, bus.step, bus.illegal});
    end
    tick();
    checks++;
    if ({bus.step, bus.illegal} !== 2'b00) begin
      failures++;
      $display("FAIL init_no_pulse: got stp/ill=%b want 00", {bus.step, bus.illegal});
    end
  endtask

  task automatic test_step();
    do_reset(1'b0, 1'b0);
    bus.A = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      checks++;
      if (bus.A_out !== (e >= 10) || bus.step !== (e == 11) || bus.illegal !== 1'b0 || bus.B_out !== 1'b0) begin
        failures++;
        $display("FAIL step_latency edge %0d: got A/B/stp/ill=%b%b%b%b want %b0%b0", e,
                 bus.A_out, bus.B_out, bus.step, bus.illegal, e >= 10, e == 11);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset(1'b0, 1'b0);
    bus.A = 1'b1;
    repeat (5) tick();
    bus.A = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      checks++;
      if (bus.A_out !== 1'b0 || bus.step !== 1'b0) begin
        failures++;
        $display("FAIL glitch_reject cycle %0d: got A/stp=%b%b want 00", e, bus.A_out, bus.step);
      end
    end
    bus.A = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (bus.A_out !== (e >= 10)) begin
        failures++;
        $display("FAIL retry_from_zero edge %0d: got %b want %b", e, bus.A_out, e >= 10);
      end
    end
  endtask

  task automatic test_illegal();
    int seen = 0;
    do_reset(1'b0, 1'b0);
    bus.A = 1'b1;
    bus.B = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (bus.illegal === 1'b1) seen++;
      checks++;
      if (bus.A_out !== (e >= 10) || bus.B_out !== (e >= 10) || bus.step !== 1'b0 || bus.illegal !== (e == 11)) begin
        failures++;
        $display("FAIL illegal_edge %0d: got A/B/stp/ill=%b%b%b%b want %b%b0%b", e,
                 bus.A_out, bus.B_out, bus.step, bus.illegal, e >= 10, e >= 10, e == 11);
      end
    end
    checks++;
    if (seen != 1 || bus.err_count !== 8'd1) begin
      failures++;
      $display("FAIL illegal_count: got pulses=%0d err=%0d want pulses=1 err=1", seen, bus.err_count);
    end
  endtask

  task automatic test_saturate();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      bus.A = ~bus.A;
      bus.B = ~bus.B;
      repeat (12) tick();
    end
    checks++;
    if (bus.err_count !== 8'd255) begin
      failures++;
      $display("FAIL err_saturate: got %0d want 255", bus.err_count);
    end
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    checks++;
    if (bus.err_count !== 8'd0) begin
      failures++;
      $display("FAIL err_clear: got %0d want 0", bus.err_count);
    end
    bus.A = ~bus.A;
    bus.B = ~bus.B;
    repeat (10) tick();
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    checks++;
    if (bus.err_count !== 8'd1 || bus.illegal !== 1'b1) begin
      failures++;
      $display("FAIL clear_with_illegal: got err=%0d ill=%b want err=1 ill=1", bus.err_count, bus.illegal);
    end
  endtask

  task automatic test_enable();
    do_reset(1'b0, 1'b0);
    bus.enable = 1'b0;
    bus.A = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (bus.A_out !== 1'b0 || bus.step !== 1'b0) begin
        failures++;
        $display("FAIL enable_hold cycle %0d: got A/stp=%b%b want 00", e, bus.A_out, bus.step);
      end
    end
    bus.enable = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (bus.A_out !== (e >= 8) || bus.step !== (e == 9)) begin
        failures++;
        $display("FAIL enable_resume edge %0d: got A/stp=%b%b want %b%b", e, bus.A_out, bus.step, e >= 8, e == 9);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 1'b0);
    bus.A = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.ready !== 1'b0 || bus.A_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got rdy/A=%b%b want 00", bus.ready, bus.A_out);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.ready !== 1'b1 || bus.A_out !== 1'b1 || bus.B_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_reinit: got rdy/A/B=%b%b%b want 110", bus.ready, bus.A_out, bus.B_out);
    end
  endtask

  task automatic test_fast();
    bus2.A = 1'b0;
    bus2.B = 1'b0;
    do_reset(1'b0, 1'b0);
    checks++;
    if (bus2.ready !== 1'b0) begin
      failures++;
      $display("FAIL fast_ready_early: got %b want 0", bus2.ready);
    end
    tick();
    checks++;
    if (bus2.ready !== 1'b1) begin
      failures++;
      $display("FAIL fast_ready: got %b want 1", bus2.ready);
    end
    bus2.A = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (bus2.A_out !== (e >= 4) || bus2.step !== (e == 5) || bus2.B_out !== 1'b0) begin
        failures++;
        $display("FAIL fast_filter edge %0d: got A/B/stp=%b%b%b want %b0%b", e,
                 bus2.A_out, bus2.B_out, bus2.step, e >= 4, e == 5);
      end
    end
  endtask

  initial begin
    bus.A = 1'b0;
    bus.B = 1'b0;
    bus.enable = 1'b1;
    bus.err_clear = 1'b0;
    bus2.A = 1'b0;
    bus2.B = 1'b0;
    bus2.enable = 1'b1;
    bus2.err_clear = 1'b0;
    test_reset();
    test_step();
    test_glitch();
    test_illegal();
    test_saturate();
    test_enable();
    test_reset_mid();
    test_fast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
